// File: rtl/lc3b_types.sv
// Shared pipeline types: elastic stage-buffer states and the MEM/WB payload width.
package lc3b_types;

    typedef enum logic [1:0] {
        PB_EMPTY = 2'd0,
        PB_FULL  = 2'd1,
        PB_SKID  = 2'd2
    } pipe_buf_state_t;

    localparam int PIPE_MEM_WB_W = 115;

endpackage

// File: rtl/register.sv
// Plain load-enabled data register; contents are deliberately not reset.
module register #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             load,
    input  logic [width-1:0] in,
    output logic [width-1:0] out
);

    logic [width-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (load) begin
            data_reg <= in;
        end
    end

    assign out = data_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: 2-entry skid buffer with registered in_ready and synchronous flush.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_buf
    import lc3b_types::*;
#(
    parameter int WIDTH       = PIPE_MEM_WB_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
`ifdef PIPE_STAGE_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_count,
`endif
    output logic [1:0]             occupancy
);

    pipe_buf_state_t state_reg;
    pipe_buf_state_t state_next;

    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_in;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= PB_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Data loads are harmless during flush: the state alone marks entries as dead.
    always_comb begin
        state_next     = state_reg;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_reg)
            PB_EMPTY: begin
                if (in_valid) begin
                    load_main  = 1'b1;
                    state_next = PB_FULL;
                end
            end
            PB_FULL: begin
                if (out_ready && in_valid) begin
                    load_main = 1'b1;
                end else if (out_ready) begin
                    state_next = PB_EMPTY;
                end else if (in_valid) begin
                    load_skid  = 1'b1;
                    state_next = PB_SKID;
                end
            end
            PB_SKID: begin
                if (out_ready) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = PB_FULL;
                end
            end
            default: state_next = PB_EMPTY;
        endcase
        if (flush) begin
            state_next = PB_EMPTY;
        end
    end

    assign main_in = main_from_skid ? skid_q : in_data;

    register #(.width(WIDTH)) u_main (
        .clk  (clk),
        .load (load_main),
        .in   (main_in),
        .out  (main_q)
    );

    register #(.width(WIDTH)) u_skid (
        .clk  (clk),
        .load (load_skid),
        .in   (in_data),
        .out  (skid_q)
    );

    assign out_valid = (state_reg != PB_EMPTY);
    assign in_ready  = (state_reg != PB_SKID);
    assign out_data  = main_q;

    always_comb begin
        case (state_reg)
            PB_FULL: occupancy = 2'd1;
            PB_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_count_reg;

    // Saturating; flush intentionally leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count_reg <= '0;
        end else if (out_valid && !out_ready && (stall_count_reg != {STALL_CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed testbench for pipe_stage_buf (covers PIPE_STAGE_STALL_CNT_EN when defined).
module tb_pipe_stage_buf;
    import lc3b_types::*;

    localparam int WIDTH       = PIPE_MEM_WB_W;
    localparam int STALL_CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_count;
`endif

    int check_cnt;
    int error_cnt;

    pipe_stage_buf #(
        .WIDTH       (WIDTH),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
`ifdef PIPE_STAGE_STALL_CNT_EN
        .stall_count (stall_count),
`endif
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
        check({tag, ".out_valid"}, 128'(out_valid), 128'(ov));
        check({tag, ".in_ready"},  128'(in_ready),  128'(ir));
        check({tag, ".occupancy"}, 128'(occupancy), 128'(occ));
    endtask

    task automatic expect_data(input string tag, input logic [WIDTH-1:0] d);
        check({tag, ".out_data"}, 128'(out_data), 128'(d));
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        expect_state("reset", 1'b0, 1'b1, 2'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("reset.stall_count", 128'(stall_count), 128'd0);
`endif

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            step();
            expect_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
            expect_data($sformatf("stream%0d", i), WIDTH'(i));
        end
        in_valid = 1'b0;
        step();
        expect_state("stream_drain", 1'b0, 1'b1, 2'd0);

        // Backpressure into skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WIDTH'('hA);
        step();
        expect_state("bp_a", 1'b1, 1'b1, 2'd1);
        expect_data("bp_a", WIDTH'('hA));
        in_data = WIDTH'('hB);
        step();
        expect_state("bp_b", 1'b1, 1'b0, 2'd2);
        expect_data("bp_b", WIDTH'('hA));
        in_data = WIDTH'('hC);
        step();
        expect_state("bp_hold", 1'b1, 1'b0, 2'd2);
        expect_data("bp_hold", WIDTH'('hA));
        out_ready = 1'b1;
        step();
        expect_state("bp_out_b", 1'b1, 1'b1, 2'd1);
        expect_data("bp_out_b", WIDTH'('hB));
        step();
        expect_state("bp_out_c", 1'b1, 1'b1, 2'd1);
        expect_data("bp_out_c", WIDTH'('hC));
        in_valid = 1'b0;
        step();
        expect_state("bp_drain", 1'b0, 1'b1, 2'd0);

        // Flush while in SKID with a concurrent upstream offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WIDTH'('h11);
        step();
        in_data = WIDTH'('h12);
        step();
        expect_state("fl_skid", 1'b1, 1'b0, 2'd2);
        flush   = 1'b1;
        in_data = WIDTH'('hF);
        step();
        expect_state("fl_after", 1'b0, 1'b1, 2'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        expect_state("fl_no_f", 1'b0, 1'b1, 2'd0);

        // Flush coinciding with a downstream transfer
        in_valid = 1'b1;
        in_data  = WIDTH'('h5);
        step();
        expect_state("fl_dn_full", 1'b1, 1'b1, 2'd1);
        expect_data("fl_dn_full", WIDTH'('h5));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        expect_state("fl_dn_empty", 1'b0, 1'b1, 2'd0);

        // Reset while holding two entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WIDTH'('h21);
        step();
        in_data = WIDTH'('h22);
        step();
        expect_state("rst_skid", 1'b1, 1'b0, 2'd2);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        reset_n = 1'b1;
        expect_state("rst_mid", 1'b0, 1'b1, 2'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("rst_mid.stall_count", 128'(stall_count), 128'd0);
`endif
        step();
        expect_state("rst_release", 1'b0, 1'b1, 2'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
        // Saturating stall counter
        in_valid = 1'b1;
        in_data  = WIDTH'('h7);
        step();
        in_valid = 1'b0;
        check("stall_start", 128'(stall_count), 128'd0);
        for (int i = 0; i < 20; i++) step();
        check("stall_sat", 128'(stall_count), 128'd15);
        expect_data("stall_hold", WIDTH'('h7));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stall_flush_keep", 128'(stall_count), 128'd15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
